// File: rtl/rv_multicycle_ctrl.sv
// Control FSM, program counter and instruction register for the multi-cycle
// RV32I core. One instruction in flight; sequences fetch, decode, execute,
// data memory access and register-file writeback.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FETCH    | imem_req high until imem_ready, then IR <= imem_rdata
// DECODE   | one cycle for the clocked decoder; opcode legality check
// EXECUTE  | one cycle of ALU; branches resolve and retire here
// MEM      | dmem_req held until dmem_ready; stores retire here
// WB       | one cycle register-file write and PC update, retire
// HALT     | absorbing after SYSTEM or illegal opcode; reset only exit
module rv_multicycle_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_addr,
    output logic            imem_req,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] imm,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] alu_result,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ready,
    output logic            rf_we,
    output logic [1:0]      wb_sel,
    output logic            alu_src_imm,
    output logic [2:0]      state,
    output logic [XLEN-1:0] retire_cnt,
    output logic            halted,
    output logic            illegal
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_ir;
    logic [XLEN-1:0] r_retire;
    logic            r_halted;
    logic            r_illegal;

    state_t          w_state_nxt;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_ir_nxt;
    logic            w_retire;
    logic            w_halt_set;
    logic            w_ill_set;
    logic            w_imem_req;
    logic            w_dmem_req;
    logic            w_dmem_we;
    logic            w_rf_we;
    logic            w_alu_src_imm;

    logic [6:0]      w_opc;
    logic            w_is_load;
    logic            w_is_store;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_pc_plus_imm;
    logic [XLEN-1:0] w_jalr_tgt;

    assign w_opc         = r_ir[6:0];
    assign w_is_load     = (w_opc == OPC_LOAD);
    assign w_is_store    = (w_opc == OPC_STORE);
    assign w_pc_plus4    = r_pc + 32'd4;
    assign w_pc_plus_imm = r_pc + imm;
    assign w_jalr_tgt    = alu_result & ~32'd1;

    // State, PC, IR, retire counter and sticky halt flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_retire  <= '0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
            if (w_retire)   r_retire  <= r_retire + 32'd1;
            if (w_halt_set) r_halted  <= 1'b1;
            if (w_ill_set)  r_illegal <= 1'b1;
        end
    end

    // Next-state, PC/IR update and Moore strobes from the registered state.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_ir_nxt      = r_ir;
        w_retire      = 1'b0;
        w_halt_set    = 1'b0;
        w_ill_set     = 1'b0;
        w_imem_req    = 1'b0;
        w_dmem_req    = 1'b0;
        w_dmem_we     = 1'b0;
        w_rf_we       = 1'b0;
        w_alu_src_imm = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_imem_req = 1'b1;
                if (imem_ready) begin
                    w_ir_nxt    = imem_rdata;
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                case (w_opc)
                    OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                    OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP:
                        w_state_nxt = S_EXECUTE;
                    OPC_SYSTEM: begin
                        w_state_nxt = S_HALT;
                        w_halt_set  = 1'b1;
                    end
                    default: begin
                        w_state_nxt = S_HALT;
                        w_ill_set   = 1'b1;
                    end
                endcase
            end
            S_EXECUTE: begin
                w_alu_src_imm = !((w_opc == OPC_OP) || (w_opc == OPC_BRANCH));
                if (w_opc == OPC_BRANCH) begin
                    w_pc_nxt    = branch_taken ? w_pc_plus_imm : w_pc_plus4;
                    w_retire    = 1'b1;
                    w_state_nxt = S_FETCH;
                end else if (w_is_load || w_is_store) begin
                    w_state_nxt = S_MEM;
                end else begin
                    w_state_nxt = S_WB;
                end
            end
            S_MEM: begin
                // Operand select held so the address stays stable while stalled.
                w_alu_src_imm = 1'b1;
                w_dmem_req    = 1'b1;
                w_dmem_we     = w_is_store;
                if (dmem_ready) begin
                    if (w_is_store) begin
                        w_pc_nxt    = w_pc_plus4;
                        w_retire    = 1'b1;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                w_alu_src_imm = (w_opc != OPC_OP);
                w_rf_we       = (r_ir[11:7] != 5'd0);
                if (w_opc == OPC_JAL)       w_pc_nxt = w_pc_plus_imm;
                else if (w_opc == OPC_JALR) w_pc_nxt = w_jalr_tgt;
                else                        w_pc_nxt = w_pc_plus4;
                w_retire    = 1'b1;
                w_state_nxt = S_FETCH;
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    // Strobes are gated by rst_n so an outstanding request drops immediately.
    assign imem_req    = rst_n & w_imem_req;
    assign dmem_req    = rst_n & w_dmem_req;
    assign dmem_we     = rst_n & w_dmem_we;
    assign rf_we       = rst_n & w_rf_we;
    assign alu_src_imm = rst_n & w_alu_src_imm;

    assign wb_sel      = w_is_load ? 2'd1 :
                         ((w_opc == OPC_JAL) || (w_opc == OPC_JALR)) ? 2'd2 : 2'd0;
    assign imem_addr   = r_pc;
    assign instr       = r_ir;
    assign state       = r_state;
    assign retire_cnt  = r_retire;
    assign halted      = r_halted;
    assign illegal     = r_illegal;

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
- Control FSM and program counter for the multi-cycle RV32I core. Sequences fetch, the clocked decoder, the ALU, data memory and register-file writeback.
- Owns the PC and instruction register (IR). Feeds the IR to the decoder and consumes the decoder's imm plus ALU status.
- One instruction is in flight at a time; no pipelining.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- imem_addr  out  32  fetch address; always equals pc.
- imem_req  out  1  fetch request.
- imem_ready  in  1  fetch data valid this cycle.
- imem_rdata  in  32  fetched instruction.
- instr  out  32  IR contents, drives the decoder's instr input.
- imm  in  32  sign-extended immediate from the decoder.
- branch_taken  in  1  ALU branch-condition result, sampled in EXECUTE.
- alu_result  in  32  ALU output; used as the JALR target.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  1 = store, 0 = load; valid only while dmem_req=1.
- dmem_ready  in  1  data memory access complete.
- rf_we  out  1  register-file write strobe.
- wb_sel  out  2  writeback source: 0 = ALU, 1 = memory, 2 = pc+4.
- alu_src_imm  out  1  ALU operand B select: 1 = imm, 0 = rs2.
- state  out  3  current FSM state, for debug.
- retire_cnt  out  32  count of retired instructions.
- halted  out  1  SYSTEM opcode reached.
- illegal  out  1  unsupported opcode reached.

Behaviour:
- Reset (rst_n low at a rising edge):
  - state=FETCH, pc=RESET_PC, IR=0, retire_cnt=0, halted=0, illegal=0.
  - While rst_n is low, imem_req, dmem_req, rf_we, dmem_we and alu_src_imm are forced to 0.
  - Reset mid-operation aborts any outstanding request: the request drops the same cycle, and ready inputs seen during reset are ignored.
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=5. All outputs are Moore decodes of the registered state and IR.
- FETCH:
  - imem_req=1 until the first cycle with imem_ready=1.
  - In that cycle: IR<=imem_rdata, go to DECODE.
  - imem_ready outside FETCH is ignored.
- DECODE:
  - Exactly 1 cycle, giving the clocked decoder time to register its fields.
  - Opcode is IR[6:0]. Legal opcodes: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011.
  - 1110011 (SYSTEM): go to HALT, halted=1.
  - Any other opcode: go to HALT, illegal=1.
- EXECUTE: exactly 1 cycle. alu_src_imm=1 for every opcode except OP (0110011) and BRANCH.
  - BRANCH: pc<=pc+imm if branch_taken, else pc+4. retire_cnt+1, go to FETCH.
  - LOAD or STORE: go to MEM.
  - All others: go to WB.
- MEM:
  - dmem_req=1; dmem_we=1 for STORE, 0 for LOAD. Held until dmem_ready=1.
  - On dmem_ready: LOAD goes to WB; STORE sets pc<=pc+4, retire_cnt+1, goes to FETCH.
- WB:
  - Exactly 1 cycle. rf_we=1 unless rd (IR[11:7]) is 0.
  - wb_sel: 1 for LOAD; 2 for JAL/JALR; 0 otherwise.
  - PC update: JAL pc<=pc+imm; JALR pc<={alu_result[31:1],1'b0}; otherwise pc+4.
  - retire_cnt+1, go to FETCH.
- HALT: absorbing state. No requests, no writes, pc frozen. Only reset exits.
- Arithmetic: all PC arithmetic is modulo 2^32; 0xFFFFFFFC+4 wraps to 0. retire_cnt wraps from 0xFFFFFFFF to 0. No alignment check on imm targets.
- Latency with zero-wait memories:
  - ALU/LUI/AUIPC/JAL/JALR: 4 cycles.
  - BRANCH: 3 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait cycle on imem_ready or dmem_ready adds exactly 1 cycle.
- rf_we is never asserted in any state except WB, and never asserted for more than 1 cycle per instruction.

Test Plan:
- Reset: hold rst_n=0 for 2 edges mid-FETCH -> pc=0, IR=0, imem_req=0, retire_cnt=0. First cycle after release: imem_req=1, imem_addr=0.
- ADDI 0x00108093 with imem_ready immediate -> states 0,1,2,4; alu_src_imm=1; rf_we high exactly 1 cycle with wb_sel=0; pc=4; retire_cnt=1. Then ADDI x0 (0x00100013) -> rf_we stays 0, retire_cnt=2.
- JAL 0xFFDFF1EF at pc=0x100, imm=0xFFFFFFFC -> rf_we=1 with wb_sel=2 (rd=x3); pc=0xFC. JALR with alu_result=0x203 -> pc=0x202.
- BEQ 0x00000463, imm=8, at pc=0x40: branch_taken=1 -> pc=0x48; branch_taken=0 -> pc=0x44. rf_we and dmem_req never assert; 3-cycle latency.
- LOAD 0x0000A103 with dmem_ready delayed 3 cycles -> dmem_req=1, dmem_we=0 for 4 cycles; then WB with wb_sel=1; total 8 cycles. Same stall pattern on a STORE gives dmem_we=1, no rf_we, and pc+4.
- Illegal 0x0000007F -> HALT, illegal=1, no request for 20 cycles. ECALL 0x00000073 -> halted=1. Reset asserted during a stalled MEM -> dmem_req drops and the FSM restarts at RESET_PC.
